change_dispenser: RTL

CHANGE_DISPENSER -- requirements
Module: change_dispenser

---
 rtl/change_dispenser.sv | 106 ++++++++++
 1 files changed

// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - greedy nickel/dime/quarter change dispenser
// Pays the owed amount one coin at a time with a mandatory low cycle between pulses.
module change_dispenser (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic [4:0] req_amount,
  output logic       req_ready,
  input  logic       hopper_ready,
  input  logic       nickel_empty,
  input  logic       dime_empty,
  input  logic       quarter_empty,
  output logic       nickel_out,
  output logic       dime_out,
  output logic       quarter_out,
  output logic [4:0] remaining,
  output logic       done,
  output logic       fault,
  input  logic       fault_clr,
  output logic [2:0] state_check
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_GAP    = 3'd2,
    ST_DONE   = 3'd3,
    ST_FAULT  = 3'd4
  } state_e;

  state_e     state_q, state_d;
  logic [4:0] rem_q, rem_d;
  logic [2:0] coin_q, coin_d;  // one-hot {quarter, dime, nickel}
  logic [2:0] pick;
  logic [4:0] pick_val;

  // Largest coin that fits and is stocked; an empty tube falls through to the next size.
  always_comb begin
    pick     = 3'b000;
    pick_val = 5'd0;
    if (!quarter_empty && rem_q >= 5'd5) begin
      pick     = 3'b100;
      pick_val = 5'd5;
    end else if (!dime_empty && rem_q >= 5'd2) begin
      pick     = 3'b010;
      pick_val = 5'd2;
    end else if (!nickel_empty && rem_q >= 5'd1) begin
      pick     = 3'b001;
      pick_val = 5'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    coin_d  = 3'b000;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          rem_d   = req_amount;
          state_d = (req_amount == 5'd0) ? ST_DONE : ST_SELECT;
        end
      end
      ST_SELECT: begin
        if (pick == 3'b000) begin
          state_d = ST_FAULT;
        end else if (hopper_ready) begin
          coin_d  = pick;
          rem_d   = rem_q - pick_val;
          state_d = ST_GAP;
        end
      end
      ST_GAP:   state_d = (rem_q != 5'd0) ? ST_SELECT : ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      ST_FAULT: begin
        if (fault_clr) begin
          state_d = ST_IDLE;
          rem_d   = 5'd0;
        end
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      rem_q   <= 5'd0;
      coin_q  <= 3'b000;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      coin_q  <= coin_d;
    end
  end

  assign req_ready   = (state_q == ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign fault       = (state_q == ST_FAULT);
  assign quarter_out = coin_q[2];
  assign dime_out    = coin_q[1];
  assign nickel_out  = coin_q[0];
  assign remaining   = rem_q;
  assign state_check = state_q;

endmodule
